lb_mem_master: RTL and testbench
================================

LB_MEM_MASTER -- requirements
Module: lb_mem_master

Interface
REQ-001 Parameter BASE_ADDR, default 8'h00, SHALL set mem address bits [31:24] of every generated access.
REQ-002 Parameter ADW, default 20, SHALL set localbus word-address width; legal range 1..22.
REQ-003 Parameter TIMEOUT, default 255, SHALL set the max cycles an access waits for ready; legal range 1..65535.
REQ-004 Port clk, input, 1: sole clock; all logic on rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port lb_write, input, 1: one-cycle localbus write strobe.
REQ-007 Port lb_read, input, 1: one-cycle localbus read strobe.
REQ-008 Port lb_addr, input, ADW: localbus word address.
REQ-009 Port lb_wdata, input, 32: localbus write data.
REQ-010 Port lb_rdata, output, 32: read data, valid while lb_rvalid=1.
REQ-011 Port lb_rvalid, output, 1: one-cycle read-completion pulse.
REQ-012 Port busy, output, 1: access in flight; requests are not accepted.
REQ-013 Port mem_packed_fwd, output, 69: {valid[68], wstrb[67:64], wdata[63:32], addr[31:0]}.
REQ-014 Port mem_packed_ret, input, 33: {ready[32], rdata[31:0]}.
REQ-015 Port clr_err, input, 1: clears timeout_err and drop_cnt.
REQ-016 Port timeout_err, output, 1: sticky timeout flag.
REQ-017 Port drop_cnt, output, 16: saturating count of rejected localbus strobes.

Function
REQ-018 FSM SHALL have states IDLE and REQ; busy SHALL equal (state==REQ).
REQ-019 In IDLE, lb_write or lb_read SHALL latch addr/data/direction and enter REQ on the next edge.
REQ-020 Generated addr SHALL be {BASE_ADDR, lb_addr zero-extended to 22 bits, 2'b00}.
REQ-021 Writes SHALL drive wstrb=4'hF and wdata=latched lb_wdata; reads SHALL drive wstrb=4'h0 and wdata=0.
REQ-022 fwd valid SHALL be 1 exactly during REQ; fwd addr, wdata and wstrb SHALL stay constant throughout REQ; all fwd bits SHALL be 0 in IDLE.
REQ-023 In REQ with ret ready=1, the FSM SHALL return to IDLE on that edge; for a read, lb_rdata SHALL capture ret rdata and lb_rvalid SHALL pulse in the following cycle.
REQ-024 Latency: strobe in cycle 0 -> valid in cycle 1; ready sampled in cycle k -> lb_rvalid in cycle k+1; minimum read latency SHALL be 2 cycles.
REQ-025 A 16-bit wait counter SHALL clear on REQ entry and increment on each REQ cycle with ready=0.
REQ-026 When the wait counter reaches TIMEOUT with ready=0, the FSM SHALL return to IDLE and set timeout_err; a timed-out read SHALL pulse lb_rvalid with lb_rdata=32'hDEADBEEF.
REQ-027 Strobes arriving in REQ SHALL be ignored and increment drop_cnt, saturating at 16'hFFFF.
REQ-028 Simultaneous lb_write and lb_read in IDLE SHALL execute only the write and increment drop_cnt.
REQ-029 A strobe in the cycle the FSM leaves REQ SHALL be dropped; acceptance starts in the first IDLE cycle.
REQ-030 In a cycle with both clr_err and a new drop or timeout event, the event SHALL win.
REQ-031 ret bits outside REQ SHALL be ignored.
REQ-032 lb_rdata SHALL hold its last value between rvalid pulses.

Reset
REQ-033 Reset SHALL force: state IDLE, mem_packed_fwd=0, lb_rvalid=0, lb_rdata=0, busy=0, timeout_err=0, drop_cnt=0, wait counter 0.
REQ-034 Reset during REQ SHALL drop valid in the next cycle and SHALL produce no lb_rvalid for the aborted access.

Verification
VER-001 BASE_ADDR=8'h01; lb_write addr=0x00010, wdata=0xCAFEF00D; ready after 3 cycles -> fwd={1,F,CAFEF00D,0x01000040} for 4 cycles, no rvalid, busy low afterwards.
VER-002 lb_read addr=0x00004; ready with rdata=0x12345678 in the first REQ cycle -> lb_rvalid at cycle 2, lb_rdata=0x12345678.
VER-003 TIMEOUT=4; lb_read and ready never asserted -> valid for 5 cycles, lb_rvalid with 0xDEADBEEF, timeout_err=1 until clr_err.
VER-004 Two lb_read strobes while busy, then one simultaneous read+write in IDLE -> drop_cnt=3, only the write issued; clr_err -> drop_cnt=0.
VER-005 Reset asserted in the second REQ cycle of a read -> fwd=0 in the next cycle, no lb_rvalid, all outputs at reset values.
VER-006 Force drop_cnt to 0xFFFF and send an extra strobe while busy -> drop_cnt stays 0xFFFF.

Source files
------------

// File: rtl/lb_mem_master_if.sv
// Localbus request/response and packed memory-bus signals of the localbus-to-memory bridge.
interface lb_mem_master_if #(
   parameter int ADW = 20
);
   logic            lb_write;
   logic            lb_read;
   logic [ADW-1:0]  lb_addr;
   logic [31:0]     lb_wdata;
   logic [31:0]     lb_rdata;
   logic            lb_rvalid;
   logic            busy;
   logic [68:0]     mem_packed_fwd;
   logic [32:0]     mem_packed_ret;

   modport master (
      input  lb_write, lb_read, lb_addr, lb_wdata, mem_packed_ret,
      output lb_rdata, lb_rvalid, busy, mem_packed_fwd
   );

   modport slave (
      output lb_write, lb_read, lb_addr, lb_wdata, mem_packed_ret,
      input  lb_rdata, lb_rvalid, busy, mem_packed_fwd
   );
endinterface

// File: rtl/lb_mem_master.sv
// Bridges one-cycle localbus strobes onto a valid/ready memory bus, one access in flight,
// with a ready timeout and a saturating count of strobes rejected while busy.
module lb_mem_master #(
   parameter logic [7:0] BASE_ADDR = 8'h00,
   parameter int         ADW       = 20,
   parameter int         TIMEOUT   = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   lb_mem_master_if.master       bus,
   input  logic                  clr_err,
   output logic                  timeout_err,
   output logic [15:0]           drop_cnt
);

   typedef enum logic {IDLE, REQ} state_t;

   state_t        state, state_n;
   logic          wr_q;
   logic [31:0]   addr_q;
   logic [31:0]   wdata_q;
   logic [15:0]   wait_cnt;
   logic [21:0]   addr_ext;
   logic          ready, strobe;
   logic          accept, done, tmo, drop;

   assign ready  = bus.mem_packed_ret[32];
   assign strobe = bus.lb_write | bus.lb_read;

   always_comb begin
      addr_ext = '0;
      addr_ext[ADW-1:0] = bus.lb_addr;
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n            = state;
      accept             = 1'b0;
      done               = 1'b0;
      tmo                = 1'b0;
      drop               = 1'b0;
      bus.busy           = 1'b0;
      bus.mem_packed_fwd = '0;
      case (state)
         IDLE: begin
            // A simultaneous read+write runs the write and counts the read as dropped.
            drop = bus.lb_write & bus.lb_read;
            if (strobe) begin
               accept  = 1'b1;
               state_n = REQ;
            end
         end
         REQ: begin
            bus.busy           = 1'b1;
            drop               = strobe;
            bus.mem_packed_fwd = {1'b1, (wr_q ? 4'hF : 4'h0), wdata_q, addr_q};
            if (ready) begin
               done    = 1'b1;
               state_n = IDLE;
            end else if (wait_cnt == 16'(TIMEOUT)) begin
               tmo     = 1'b1;
               state_n = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q          <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         wait_cnt      <= '0;
         bus.lb_rdata  <= '0;
         bus.lb_rvalid <= 1'b0;
         timeout_err   <= 1'b0;
         drop_cnt      <= '0;
      end else begin
         bus.lb_rvalid <= 1'b0;
         if (accept) begin
            wr_q     <= bus.lb_write;
            addr_q   <= {BASE_ADDR, addr_ext, 2'b00};
            wdata_q  <= bus.lb_write ? bus.lb_wdata : 32'h0;
            wait_cnt <= '0;
         end else if (state == REQ && !ready && !tmo) begin
            wait_cnt <= wait_cnt + 16'd1;
         end

         if (done && !wr_q) begin
            bus.lb_rdata  <= bus.mem_packed_ret[31:0];
            bus.lb_rvalid <= 1'b1;
         end else if (tmo && !wr_q) begin
            bus.lb_rdata  <= 32'hDEADBEEF;
            bus.lb_rvalid <= 1'b1;
         end

         // New events take precedence over a same-cycle clear.
         if (tmo)          timeout_err <= 1'b1;
         else if (clr_err) timeout_err <= 1'b0;

         if (drop) begin
            if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
         end else if (clr_err) begin
            drop_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_lb_mem_master.sv
// Directed-vector bench for lb_mem_master (BASE_ADDR=8'h01, ADW=20, TIMEOUT=4).
module tb_lb_mem_master;

   logic        clk = 1'b0;
   logic        reset;
   logic        clr_err;
   logic        timeout_err;
   logic [15:0] drop_cnt;
   int          n_cmp = 0;
   int          n_err = 0;

   lb_mem_master_if #(.ADW(20)) bus();

   lb_mem_master #(.BASE_ADDR(8'h01), .ADW(20), .TIMEOUT(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .clr_err     (clr_err),
      .timeout_err (timeout_err),
      .drop_cnt    (drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.lb_write       = 1'b0;
      bus.lb_read        = 1'b0;
      bus.lb_addr        = '0;
      bus.lb_wdata       = '0;
      bus.mem_packed_ret = '0;
      clr_err            = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      bus.lb_read = 1'b1;
      bus.mem_packed_ret = {1'b1, 32'hFFFFFFFF};
      step();
      step();
      n_cmp++; if (bus.mem_packed_fwd !== 69'h0) begin n_err++; $display("FAIL reset_fwd: got %h want 0", bus.mem_packed_fwd); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      n_cmp++; if (bus.lb_rvalid !== 1'b0) begin n_err++; $display("FAIL reset_rvalid: got %b want 0", bus.lb_rvalid); end
      n_cmp++; if (bus.lb_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", bus.lb_rdata); end
      n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL reset_terr: got %b want 0", timeout_err); end
      n_cmp++; if (drop_cnt !== 16'h0) begin n_err++; $display("FAIL reset_drop: got %h want 0", drop_cnt); end
      idle_inputs();
      reset = 1'b0;
      step();
   endtask

   task automatic test_write();
      bus.lb_write = 1'b1;
      bus.lb_addr  = 20'h00010;
      bus.lb_wdata = 32'hCAFEF00D;
      step();
      idle_inputs();
      for (int i = 1; i <= 4; i++) begin
         if (i == 4) bus.mem_packed_ret = {1'b1, 32'h0};
         n_cmp++; if (bus.mem_packed_fwd !== {1'b1, 4'hF, 32'hCAFEF00D, 32'h01000040}) begin n_err++; $display("FAIL wr_fwd c%0d: got %h want %h", i, bus.mem_packed_fwd, {1'b1, 4'hF, 32'hCAFEF00D, 32'h01000040}); end
         n_cmp++; if (bus.lb_rvalid !== 1'b0) begin n_err++; $display("FAIL wr_rvalid c%0d: got %b want 0", i, bus.lb_rvalid); end
         step();
      end
      bus.mem_packed_ret = '0;
      n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL wr_busy_after: got %b want 0", bus.busy); end
      n_cmp++; if (bus.mem_packed_fwd !== 69'h0) begin n_err++; $display("FAIL wr_fwd_after: got %h want 0", bus.mem_packed_fwd); end
      n_cmp++; if (bus.lb_rvalid !== 1'b0) begin n_err++; $display("FAIL wr_rvalid_after: got %b want 0", bus.lb_rvalid); end
   endtask

   task automatic test_read_min();
      bus.lb_read = 1'b1;
      bus.lb_addr = 20'h00004;
      step();
      idle_inputs();
      bus.mem_packed_ret = {1'b1, 32'h12345678};
      n_cmp++; if (bus.mem_packed_fwd !== {1'b1, 4'h0, 32'h0, 32'h01000010}) begin n_err++; $display("FAIL rd_fwd: got %h want %h", bus.mem_packed_fwd, {1'b1, 4'h0, 32'h0, 32'h01000010}); end
      n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL rd_busy: got %b want 1", bus.busy); end
      step();
      bus.mem_packed_ret = '0;
      n_cmp++; if (bus.lb_rvalid !== 1'b1) begin n_err++; $display("FAIL rd_rvalid: got %b want 1", bus.lb_rvalid); end
      n_cmp++; if (bus.lb_rdata !== 32'h12345678) begin n_err++; $display("FAIL rd_rdata: got %h want 12345678", bus.lb_rdata); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rd_busy_after: got %b want 0", bus.busy); end
      step();
      n_cmp++; if (bus.lb_rvalid !== 1'b0) begin n_err++; $display("FAIL rd_rvalid_pulse: got %b want 0", bus.lb_rvalid); end
      n_cmp++; if (bus.lb_rdata !== 32'h12345678) begin n_err++; $display("FAIL rd_rdata_hold: got %h want 12345678", bus.lb_rdata); end
   endtask

   task automatic test_ret_ignored();
      bus.mem_packed_ret = {1'b1, 32'hABCDABCD};
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++; if (bus.lb_rvalid !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL idle_ret_ignored: got rvalid=%b busy=%b want 0 0", bus.lb_rvalid, bus.busy); end
         n_cmp++; if (bus.lb_rdata !== 32'h12345678) begin n_err++; $display("FAIL idle_rdata_hold: got %h want 12345678", bus.lb_rdata); end
      end
      idle_inputs();
   endtask

   task automatic test_timeout();
      bus.lb_read = 1'b1;
      bus.lb_addr = 20'h00008;
      step();
      idle_inputs();
      n_cmp++; if (bus.mem_packed_fwd !== {1'b1, 4'h0, 32'h0, 32'h01000020}) begin n_err++; $display("FAIL to_fwd: got %h want %h", bus.mem_packed_fwd, {1'b1, 4'h0, 32'h0, 32'h01000020}); end
      for (int i = 1; i <= 5; i++) begin
         n_cmp++; if (bus.mem_packed_fwd[68] !== 1'b1 || bus.lb_rvalid !== 1'b0) begin n_err++; $display("FAIL to_wait c%0d: got valid=%b rvalid=%b want 1 0", i, bus.mem_packed_fwd[68], bus.lb_rvalid); end
         if (i == 5) clr_err = 1'b1;
         step();
      end
      clr_err = 1'b0;
      n_cmp++; if (bus.busy !== 1'b0 || bus.mem_packed_fwd !== 69'h0) begin n_err++; $display("FAIL to_exit: got busy=%b fwd=%h want 0 0", bus.busy, bus.mem_packed_fwd); end
      n_cmp++; if (bus.lb_rvalid !== 1'b1) begin n_err++; $display("FAIL to_rvalid: got %b want 1", bus.lb_rvalid); end
      n_cmp++; if (bus.lb_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL to_rdata: got %h want deadbeef", bus.lb_rdata); end
      n_cmp++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL to_err_set: got %b want 1", timeout_err); end
      step();
      step();
      n_cmp++; if (timeout_err !== 1'b1 || bus.lb_rvalid !== 1'b0) begin n_err++; $display("FAIL to_err_sticky: got err=%b rvalid=%b want 1 0", timeout_err, bus.lb_rvalid); end
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL to_err_clr: got %b want 0", timeout_err); end
   endtask

   task automatic test_drops();
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      n_cmp++; if (drop_cnt !== 16'h0) begin n_err++; $display("FAIL drop_init: got %h want 0", drop_cnt); end
      bus.lb_read = 1'b1;
      bus.lb_addr = 20'h00001;
      step();
      step();
      step();
      idle_inputs();
      bus.mem_packed_ret = {1'b1, 32'hAAAA5555};
      n_cmp++; if (drop_cnt !== 16'd2) begin n_err++; $display("FAIL drop_busy: got %0d want 2", drop_cnt); end
      step();
      bus.mem_packed_ret = '0;
      n_cmp++; if (bus.lb_rvalid !== 1'b1 || bus.lb_rdata !== 32'hAAAA5555) begin n_err++; $display("FAIL drop_rd: got rvalid=%b rdata=%h want 1 aaaa5555", bus.lb_rvalid, bus.lb_rdata); end
      bus.lb_write = 1'b1;
      bus.lb_read  = 1'b1;
      bus.lb_addr  = 20'h00003;
      bus.lb_wdata = 32'h11112222;
      step();
      idle_inputs();
      n_cmp++; if (drop_cnt !== 16'd3) begin n_err++; $display("FAIL drop_rw: got %0d want 3", drop_cnt); end
      n_cmp++; if (bus.mem_packed_fwd !== {1'b1, 4'hF, 32'h11112222, 32'h0100000C}) begin n_err++; $display("FAIL drop_rw_fwd: got %h want %h", bus.mem_packed_fwd, {1'b1, 4'hF, 32'h11112222, 32'h0100000C}); end
      bus.mem_packed_ret = {1'b1, 32'h0};
      step();
      bus.mem_packed_ret = '0;
      n_cmp++; if (bus.lb_rvalid !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL drop_rw_done: got rvalid=%b busy=%b want 0 0", bus.lb_rvalid, bus.busy); end
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      n_cmp++; if (drop_cnt !== 16'h0) begin n_err++; $display("FAIL drop_clr: got %h want 0", drop_cnt); end
   endtask

   task automatic test_back_to_back();
      bus.lb_read = 1'b1;
      bus.lb_addr = 20'h00005;
      step();
      // Strobe in the exit cycle, with a simultaneous clear.
      bus.lb_read  = 1'b0;
      bus.lb_write = 1'b1;
      bus.lb_addr  = 20'h00006;
      bus.lb_wdata = 32'h00000077;
      clr_err      = 1'b1;
      bus.mem_packed_ret = {1'b1, 32'h5A5A5A5A};
      step();
      idle_inputs();
      n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL b2b_exit_drop_busy: got %b want 0", bus.busy); end
      n_cmp++; if (drop_cnt !== 16'd1) begin n_err++; $display("FAIL b2b_drop_over_clr: got %0d want 1", drop_cnt); end
      n_cmp++; if (bus.lb_rvalid !== 1'b1 || bus.lb_rdata !== 32'h5A5A5A5A) begin n_err++; $display("FAIL b2b_rd: got rvalid=%b rdata=%h want 1 5a5a5a5a", bus.lb_rvalid, bus.lb_rdata); end
      bus.lb_write = 1'b1;
      bus.lb_addr  = 20'h00006;
      bus.lb_wdata = 32'h00000077;
      step();
      idle_inputs();
      n_cmp++; if (bus.busy !== 1'b1 || bus.mem_packed_fwd !== {1'b1, 4'hF, 32'h00000077, 32'h01000018}) begin n_err++; $display("FAIL b2b_accept: got busy=%b fwd=%h want 1 %h", bus.busy, bus.mem_packed_fwd, {1'b1, 4'hF, 32'h00000077, 32'h01000018}); end
      bus.mem_packed_ret = {1'b1, 32'h0};
      step();
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      bus.lb_read = 1'b1;
      bus.lb_addr = 20'h00009;
      step();
      idle_inputs();
      step();
      n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL rst_mid_busy: got %b want 1", bus.busy); end
      reset = 1'b1;
      step();
      reset = 1'b0;
      n_cmp++; if (bus.mem_packed_fwd !== 69'h0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_fwd: got fwd=%h busy=%b want 0 0", bus.mem_packed_fwd, bus.busy); end
      n_cmp++; if (bus.lb_rvalid !== 1'b0 || bus.lb_rdata !== 32'h0) begin n_err++; $display("FAIL rst_mid_rd: got rvalid=%b rdata=%h want 0 0", bus.lb_rvalid, bus.lb_rdata); end
      n_cmp++; if (drop_cnt !== 16'h0 || timeout_err !== 1'b0) begin n_err++; $display("FAIL rst_mid_err: got drop=%h terr=%b want 0 0", drop_cnt, timeout_err); end
      step();
      n_cmp++; if (bus.lb_rvalid !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_after: got rvalid=%b busy=%b want 0 0", bus.lb_rvalid, bus.busy); end
   endtask

   task automatic test_saturate();
      force dut.drop_cnt = 16'hFFFF;
      step();
      release dut.drop_cnt;
      bus.lb_read = 1'b1;
      bus.lb_addr = 20'h00002;
      step();
      step();
      bus.lb_read  = 1'b0;
      bus.lb_write = 1'b1;
      step();
      idle_inputs();
      n_cmp++; if (drop_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_hold: got %h want ffff", drop_cnt); end
      bus.mem_packed_ret = {1'b1, 32'h0BADF00D};
      step();
      bus.mem_packed_ret = '0;
      n_cmp++; if (drop_cnt !== 16'hFFFF || bus.lb_rvalid !== 1'b1) begin n_err++; $display("FAIL sat_end: got drop=%h rvalid=%b want ffff 1", drop_cnt, bus.lb_rvalid); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read_min();
      test_ret_ignored();
      test_timeout();
      test_drops();
      test_back_to_back();
      test_reset_mid();
      test_saturate();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
